// File: rtl/alu_seq.sv
// Multi-cycle unsigned ALU: single-cycle ADD/SUB/NAND/LT/LTE, iterative
// shift-add MULT and restoring DIV/MOD behind a start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int STEPS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_status,
  output logic             zero_flag,
  output logic             carry_flag
);

  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MULT, OP_NAND, OP_DIV, OP_MOD, OP_LT, OP_LTE
  } op_t;

  state_t             state;
  op_t                op_q;
  op_t                op_in;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
  logic [WIDTH-1:0]   mplier, divisor, quot, rem, quot_nxt, rem_nxt;
  logic [WIDTH:0]     sum_ext, diff_ext, rem_shift, rem_trial;
  logic [WIDTH-1:0]   fin_val;
  logic               fin_carry, finish, last_step;

  assign op_in     = op_t'(alu_op);
  assign sum_ext   = {1'b0, operand_a} + {1'b0, operand_b};
  assign diff_ext  = {1'b0, operand_a} - {1'b0, operand_b};
  assign last_step = (count == CW'(STEPS - 1));

  // One iteration step of each engine; used both for state update and for
  // registering the final answer on the last step.
  assign prod_nxt  = mplier[0] ? prod + mcand : prod;
  assign rem_shift = {rem, quot[WIDTH-1]};
  assign rem_trial = rem_shift - {1'b0, divisor};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    rem_nxt  = rem_shift[WIDTH-1:0];
    quot_nxt = {quot[WIDTH-2:0], 1'b0};
    if (!rem_trial[WIDTH]) begin
      rem_nxt  = rem_trial[WIDTH-1:0];
      quot_nxt = {quot[WIDTH-2:0], 1'b1};
    end
  end

  // Value and carry registered on the edge that enters DONE.
  always_comb begin
    fin_val   = '0;
    fin_carry = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        finish = 1'b1;
        case (op_in)
          OP_ADD:  begin fin_val = sum_ext[WIDTH-1:0];  fin_carry = sum_ext[WIDTH];  end
          OP_SUB:  begin fin_val = diff_ext[WIDTH-1:0]; fin_carry = diff_ext[WIDTH]; end
          OP_MULT: finish = 1'b0;
          OP_NAND: fin_val = ~(operand_a & operand_b);
          OP_DIV:  if (operand_b != '0) finish = 1'b0;
                   else begin fin_val = '1; fin_carry = 1'b1; end
          OP_MOD:  if (operand_b != '0) finish = 1'b0;
                   else begin fin_val = operand_a; fin_carry = 1'b1; end
          OP_LT:   fin_val = WIDTH'(operand_a < operand_b);
          OP_LTE:  fin_val = WIDTH'(operand_a <= operand_b);
          default: ;
        endcase
      end
      S_MUL: if (last_step) begin
        finish    = 1'b1;
        fin_val   = prod_nxt[WIDTH-1:0];
        fin_carry = |prod_nxt[2*WIDTH-1:WIDTH];
      end
      S_DIV: if (last_step) begin
        finish  = 1'b1;
        fin_val = (op_q == OP_MOD) ? rem_nxt : quot_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: datapath registers are cleared along with control so an aborted op leaves nothing behind.
      state      <= S_IDLE;
      op_q       <= OP_ADD;
      count      <= '0;
      mcand      <= '0;
      mplier     <= '0;
      prod       <= '0;
      divisor    <= '0;
      quot       <= '0;
      rem        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      alu_status <= '0;
      zero_flag  <= 1'b1;
      carry_flag <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      done <= 1'b0;
      if (finish) begin
        result     <= fin_val;
        alu_status <= fin_val;
        zero_flag  <= (fin_val == '0);
        carry_flag <= fin_carry;
        done       <= 1'b1;
        busy       <= 1'b0;
        state      <= S_DONE;
      end
      case (state)
        S_IDLE: if (start) begin
          op_q  <= op_in;
          count <= '0;
          if (!finish) begin
            busy <= 1'b1;
            if (op_in == OP_MULT) begin
              mcand  <= {{WIDTH{1'b0}}, operand_a};
              mplier <= operand_b;
              prod   <= '0;
              state  <= S_MUL;
            end else begin
              quot    <= operand_a;
              divisor <= operand_b;
              rem     <= '0;
              state   <= S_DIV;
            end
          end
        end
        S_MUL: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
        end
        S_DIV: begin
          quot  <= quot_nxt;
          rem   <= rem_nxt;
          count <= count + CW'(1);
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results on issue, a
// negedge monitor pops and checks on every done pulse.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   alu_op;
  logic [W-1:0] operand_a, operand_b;
  logic         busy, done, zero_flag, carry_flag;
  logic [W-1:0] result, alu_status;

  alu_seq #(.WIDTH(W), .STEPS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op),
    .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
    .result(result), .alu_status(alu_status), .zero_flag(zero_flag),
    .carry_flag(carry_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         carry;
    int           exp_cyc;
    int           exp_busy;
  } item_t;

  item_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from plain unsigned arithmetic.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] res, output logic carry);
    int unsigned ua, ub, t;
    ua = a; ub = b; carry = 1'b0; res = '0;
    case (op)
      3'd0: begin t = ua + ub; res = W'(t); carry = (t > 65535); end
      3'd1: begin res = W'(ua - ub); carry = (ua < ub); end
      3'd2: begin t = ua * ub; res = W'(t); carry = (t > 65535); end
      3'd3: res = ~(a & b);
      3'd4: if (ub == 0) begin res = '1; carry = 1'b1; end else res = W'(ua / ub);
      3'd5: if (ub == 0) begin res = a; carry = 1'b1; end else res = W'(ua % ub);
      3'd6: res = (ua < ub) ? 16'd1 : 16'd0;
      3'd7: res = (ua <= ub) ? 16'd1 : 16'd0;
      default: res = '0;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [W-1:0] b);
    return (op == 3'd2 || ((op == 3'd4 || op == 3'd5) && b != 0)) ? 17 : 1;
  endfunction

  // Drive a request and, if tracked, push its expected response.
  task automatic load(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit track, input int extra);
    item_t it;
    int lat;
    start = 1'b1; alu_op = op; operand_a = a; operand_b = b;
    if (track) begin
      model(op, a, b, it.res, it.carry);
      lat         = latency(op, b);
      it.exp_cyc  = cyc + lat + extra;
      it.exp_busy = lat - 1;
      exp_q.push_back(it);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    load(op, a, b, track, 0);
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = W'($urandom);
    operand_b = W'($urandom);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) check("done_timeout", done, 1'b1);
    @(negedge clk);
  endtask

  // Monitor: busy run length, latency and all result ports on each done.
  int busy_run = 0;
  item_t mon_it;
  always @(negedge clk) begin
    if (busy) busy_run++;
    else if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", done, 1'b0);
      else begin
        mon_it = exp_q.pop_front();
        check("result",     result,            mon_it.res);
        check("alu_status", alu_status,        mon_it.res);
        check("zero_flag",  zero_flag,         (mon_it.res == 0));
        check("carry_flag", carry_flag,        mon_it.carry);
        check("latency",    cyc,               mon_it.exp_cyc);
        check("busy_len",   busy_run,          mon_it.exp_busy);
      end
      busy_run = 0;
    end else busy_run = 0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  logic [2:0] single_ops [7] = '{3'd0, 3'd1, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5};

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    reset = 1'b1; start = 1'b0; alu_op = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   busy,       1'b0);
    check("rst_done",   done,       1'b0);
    check("rst_result", result,     16'h0);
    check("rst_status", alu_status, 16'h0);
    check("rst_zero",   zero_flag,  1'b1);
    check("rst_carry",  carry_flag, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    issue(3'd0, 16'hFFFF, 16'h0002, 1); wait_done();
    check("add_wrap_held", result, 16'h0001);
    issue(3'd1, 16'd5, 16'd5, 1); wait_done();
    check("sub_eq_zero", zero_flag, 1'b1);
    issue(3'd6, 16'd3, 16'd7, 1); wait_done();
    issue(3'd7, 16'd7, 16'd7, 1); wait_done();
    issue(3'd6, 16'd7, 16'd3, 1); wait_done();
    check("lt_false", result, 16'h0);

    // MULT with an ADD start pulse during busy that must be ignored.
    issue(3'd2, 16'd300, 16'd300, 1);
    repeat (3) @(negedge clk);
    load(3'd0, 16'd1, 16'd1, 0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    check("mult_const", result, 16'h5F90);

    issue(3'd4, 16'd1000, 16'd7, 1); wait_done();
    check("div_const", result, 16'd142);
    issue(3'd5, 16'd1000, 16'd7, 1); wait_done();
    issue(3'd4, 16'd1234, 16'd0, 1); wait_done();
    issue(3'd5, 16'd1234, 16'd0, 1); wait_done();
    check("mod_by0_const", result, 16'd1234);
    issue(3'd3, 16'hF0F0, 16'hFF00, 1); wait_done();
    check("nand_const", result, 16'h0FFF);

    // start held high: one acceptance every two cycles.
    for (int i = 0; i < 12; i++) begin
      op = single_ops[$urandom_range(0, 6)];
      a  = W'($urandom);
      b  = (op == 3'd4 || op == 3'd5) ? 16'd0 : W'($urandom);
      load(op, a, b, 1, (i == 0) ? 0 : 1);
      @(negedge clk);
      if (i != 0) @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);

    // Reset mid-division: op aborts with no done pulse.
    issue(3'd4, 16'd1000, 16'd7, 0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy",   busy,      1'b0);
    check("abort_done",   done,      1'b0);
    check("abort_result", result,    16'h0);
    check("abort_zero",   zero_flag, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    issue(3'd0, 16'd2, 16'd3, 1); wait_done();
    check("post_abort_add", result, 16'd5);

    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 16'd0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = a;
        default: b = W'($urandom);
      endcase
      issue(op, a, b, 1);
      wait_done();
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
